// File: rtl/prach_pkg.sv
// Shared constants and types for the PRACH half-band input scheduler.
package prach_pkg;

    localparam int unsigned NUM_CHANNEL      = 128;
    localparam int unsigned NUM_CHANNEL_USED = 48;
    localparam int unsigned DATA_WIDTH       = 16;
    localparam int unsigned CHN_W            = 8;
    localparam int unsigned ADDR_W           = $clog2(NUM_CHANNEL);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        RUN       = 2'd1,
        ERR       = 2'd2
    } sched_state_e;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_e;

endpackage

// File: rtl/prach_chn_ram.sv
// Per-channel even-phase sample store: 1 write, 1 unregistered read, read-first.
module prach_chn_ram
    import prach_pkg::*;
#(
    parameter int unsigned DEPTH = NUM_CHANNEL,
    parameter int unsigned WIDTH = DATA_WIDTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read returns the pre-edge contents.
    assign rd_data_c = mem[raddr];

endmodule

// File: rtl/prach_hb_sched.sv
// Pairs even/odd TDM samples per channel into (dp1, dp2) beats for the
// half-band decimator, with channel-sequence checking and frame sync tracking.
module prach_hb_sched
    import prach_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_dq,
    input  logic                  din_dv,
    input  logic [CHN_W-1:0]      din_chn,
    input  logic                  sync_in,
    output logic [DATA_WIDTH-1:0] dout_dp1,
    output logic [DATA_WIDTH-1:0] dout_dp2,
    output logic                  dout_dv,
    output logic [CHN_W-1:0]      dout_chn,
    output logic                  sync_out,
    output logic                  seq_err,
    output logic [1:0]            state_o
);

    sched_state_e          state_q, state_d;
    logic [CHN_W-1:0]      exp_chn_q, exp_chn_d;
    phase_e                phase_q, phase_d;
    logic                  sync_pend_q, sync_pend_d;
    logic [DATA_WIDTH-1:0] dp1_q, dp1_d, dp2_q, dp2_d;
    logic [CHN_W-1:0]      chn_q, chn_d;
    logic                  dv_q, dv_d, sync_out_q, sync_out_d, seq_err_q, seq_err_d;

    logic                  sync_acc;
    logic                  proc;
    logic [CHN_W-1:0]      proc_chn;
    phase_e                proc_phase;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rd_data_c;

    assign sync_acc = din_dv & sync_in;

    prach_chn_ram #(
        .DEPTH (NUM_CHANNEL),
        .WIDTH (DATA_WIDTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .waddr     (ADDR_W'(proc_chn)),
        .wdata     (din_dq),
        .raddr     (ADDR_W'(proc_chn)),
        .rd_data_c (ram_rd_data_c)
    );

    always_comb begin
        state_d     = state_q;
        exp_chn_d   = exp_chn_q;
        phase_d     = phase_q;
        sync_pend_d = sync_pend_q;
        dp1_d       = dp1_q;
        dp2_d       = dp2_q;
        chn_d       = chn_q;
        dv_d        = 1'b0;
        sync_out_d  = 1'b0;
        seq_err_d   = 1'b0;
        proc        = 1'b0;
        proc_chn    = exp_chn_q;
        proc_phase  = phase_q;
        ram_we      = 1'b0;

        unique case (state_q)
            WAIT_SYNC: begin
                if (sync_acc) begin
                    state_d = RUN;
                    proc    = 1'b1;
                end
            end
            RUN: begin
                // Channels beyond the used range never equal exp_chn.
                if (sync_acc) begin
                    proc = 1'b1;
                end else if (din_dv) begin
                    if (din_chn == exp_chn_q) begin
                        proc = 1'b1;
                    end else begin
                        state_d   = ERR;
                        seq_err_d = 1'b1;
                    end
                end
            end
            ERR: begin
                state_d = sync_acc ? RUN : WAIT_SYNC;
                proc    = sync_acc;
            end
            default: state_d = WAIT_SYNC;
        endcase

        // An accepted sync always restarts at chn 0, even phase.
        if (proc && sync_acc) begin
            proc_chn    = '0;
            proc_phase  = EVEN;
            sync_pend_d = 1'b1;
        end

        if (proc) begin
            if (proc_phase == EVEN) begin
                ram_we = 1'b1;
            end else begin
                dv_d        = 1'b1;
                dp1_d       = din_dq;
                dp2_d       = ram_rd_data_c;
                chn_d       = proc_chn;
                sync_out_d  = sync_pend_q;
                sync_pend_d = 1'b0;
            end
            if (proc_chn == CHN_W'(NUM_CHANNEL_USED - 1)) begin
                exp_chn_d = '0;
                phase_d   = (proc_phase == EVEN) ? ODD : EVEN;
            end else begin
                exp_chn_d = proc_chn + CHN_W'(1);
                phase_d   = proc_phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SYNC;
            exp_chn_q   <= '0;
            phase_q     <= EVEN;
            sync_pend_q <= 1'b0;
            dp1_q       <= '0;
            dp2_q       <= '0;
            chn_q       <= '0;
            dv_q        <= 1'b0;
            sync_out_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_chn_q   <= exp_chn_d;
            phase_q     <= phase_d;
            sync_pend_q <= sync_pend_d;
            dp1_q       <= dp1_d;
            dp2_q       <= dp2_d;
            chn_q       <= chn_d;
            dv_q        <= dv_d;
            sync_out_q  <= sync_out_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign dout_dp1 = dp1_q;
    assign dout_dp2 = dp2_q;
    assign dout_dv  = dv_q;
    assign dout_chn = chn_q;
    assign sync_out = sync_out_q;
    assign seq_err  = seq_err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_prach_hb_sched.sv
// Directed bench for prach_hb_sched: hand-computed pairing, error, resync and reset cases.
module tb_prach_hb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din_dq;
    logic        din_dv;
    logic [7:0]  din_chn;
    logic        sync_in;
    logic [15:0] dout_dp1, dout_dp2;
    logic        dout_dv;
    logic [7:0]  dout_chn;
    logic        sync_out, seq_err;
    logic [1:0]  state_o;

    int n_chk  = 0;
    int n_pass = 0;

    prach_hb_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dq   (din_dq),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out),
        .seq_err  (seq_err),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    // Drive one input cycle, then settle just after the capturing edge.
    task automatic step(input logic dv, input logic sy, input logic [7:0] ch, input logic [15:0] dq);
        @(negedge clk);
        din_dv  = dv;
        sync_in = sy;
        din_chn = ch;
        din_dq  = dq;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; din_dv = 1'b0; sync_in = 1'b0; din_chn = '0; din_dq = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sync on chn 0 followed by a full even period with base+chn.
    task automatic send_sync_even(input logic [15:0] base);
        for (int c = 0; c < 48; c++)
            step(1'b1, c == 0, 8'(c), base + 16'(c));
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++;
        if (dout_dv !== 1'b0 || dout_dp1 !== 16'h0 || dout_dp2 !== 16'h0 || dout_chn !== 8'h0 ||
            sync_out !== 1'b0 || seq_err !== 1'b0 || state_o !== 2'd0)
            $display("FAIL reset_state: dv=%b dp1=%h dp2=%h chn=%0d so=%b err=%b st=%0d, need all 0",
                     dout_dv, dout_dp1, dout_dp2, dout_chn, sync_out, seq_err, state_o);
        else n_pass++;
    endtask

    task automatic test_stream(input int gap, input string nm);
        logic [15:0] l1, l2, dq;
        logic [7:0]  lc;
        logic        odd, esync;
        do_reset();
        l1 = '0; l2 = '0; lc = '0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 48; c++) begin
                odd = (p % 2) == 1;
                dq  = odd ? 16'h2000 + 16'(c) : 16'h1000 + 16'(c);
                step(1'b1, p == 0 && c == 0, 8'(c), dq);
                esync = (p == 1 && c == 0);
                if (odd) begin
                    l1 = dq; l2 = 16'h1000 + 16'(c); lc = 8'(c);
                end
                n_chk++;
                if (dout_dv !== odd || sync_out !== esync || seq_err !== 1'b0 ||
                    dout_dp1 !== l1 || dout_dp2 !== l2 || dout_chn !== lc)
                    $display("FAIL %s p%0d c%0d: dv=%b so=%b err=%b dp1=%h dp2=%h chn=%0d, need dv=%b so=%b err=0 dp1=%h dp2=%h chn=%0d",
                             nm, p, c, dout_dv, sync_out, seq_err, dout_dp1, dout_dp2, dout_chn,
                             odd, esync, l1, l2, lc);
                else n_pass++;
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b0, 8'hAA, 16'hDEAD);
                    n_chk++;
                    if (dout_dv !== 1'b0 || sync_out !== 1'b0 || dout_dp1 !== l1 ||
                        dout_dp2 !== l2 || dout_chn !== lc)
                        $display("FAIL %s_gap p%0d c%0d: dv=%b so=%b dp1=%h dp2=%h chn=%0d, need dv=0 so=0 dp1=%h dp2=%h chn=%0d",
                                 nm, p, c, dout_dv, sync_out, dout_dp1, dout_dp2, dout_chn, l1, l2, lc);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_seq_err();
        do_reset();
        send_sync_even(16'h1000);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 8'(c), 16'h2000 + 16'(c));
        n_chk++;
        if (dout_dv !== 1'b1 || dout_dp2 !== 16'h1003 || dout_dp1 !== 16'h2003)
            $display("FAIL err_pre: dv=%b dp1=%h dp2=%h, need 1 2003 1003", dout_dv, dout_dp1, dout_dp2);
        else n_pass++;
        step(1'b1, 1'b0, 8'd5, 16'h2005);
        n_chk++;
        if (dout_dv !== 1'b0 || seq_err !== 1'b1 || state_o !== 2'd2)
            $display("FAIL err_pulse: dv=%b err=%b st=%0d, need 0 1 2", dout_dv, seq_err, state_o);
        else n_pass++;
        step(1'b1, 1'b0, 8'd5, 16'h2005);
        n_chk++;
        if (dout_dv !== 1'b0 || seq_err !== 1'b0 || state_o !== 2'd0)
            $display("FAIL err_end: dv=%b err=%b st=%0d, need 0 0 0", dout_dv, seq_err, state_o);
        else n_pass++;
        for (int c = 6; c < 12; c++) begin
            step(1'b1, 1'b0, 8'(c), 16'h2000 + 16'(c));
            n_chk++;
            if (dout_dv !== 1'b0 || seq_err !== 1'b0 || state_o !== 2'd0)
                $display("FAIL err_drop c%0d: dv=%b err=%b st=%0d, need 0 0 0", c, dout_dv, seq_err, state_o);
            else n_pass++;
        end
        send_sync_even(16'h3000);
        step(1'b1, 1'b0, 8'd0, 16'h4000);
        n_chk++;
        if (dout_dv !== 1'b1 || sync_out !== 1'b1 || dout_dp1 !== 16'h4000 ||
            dout_dp2 !== 16'h3000 || dout_chn !== 8'd0)
            $display("FAIL err_resume: dv=%b so=%b dp1=%h dp2=%h chn=%0d, need 1 1 4000 3000 0",
                     dout_dv, sync_out, dout_dp1, dout_dp2, dout_chn);
        else n_pass++;
    endtask

    task automatic test_err_cycle_sync();
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b1, c == 0, 8'(c), 16'h1000 + 16'(c));
        step(1'b1, 1'b0, 8'd7, 16'h1007);
        n_chk++;
        if (seq_err !== 1'b1 || state_o !== 2'd2)
            $display("FAIL errsync_pulse: err=%b st=%0d, need 1 2", seq_err, state_o);
        else n_pass++;
        step(1'b1, 1'b1, 8'd0, 16'h7000);
        n_chk++;
        if (state_o !== 2'd1 || seq_err !== 1'b0 || dout_dv !== 1'b0)
            $display("FAIL errsync_accept: st=%0d err=%b dv=%b, need 1 0 0", state_o, seq_err, dout_dv);
        else n_pass++;
        for (int c = 1; c < 48; c++) step(1'b1, 1'b0, 8'(c), 16'h7000 + 16'(c));
        step(1'b1, 1'b0, 8'd0, 16'h7100);
        n_chk++;
        if (dout_dv !== 1'b1 || sync_out !== 1'b1 || dout_dp1 !== 16'h7100 || dout_dp2 !== 16'h7000)
            $display("FAIL errsync_out: dv=%b so=%b dp1=%h dp2=%h, need 1 1 7100 7000",
                     dout_dv, sync_out, dout_dp1, dout_dp2);
        else n_pass++;
    endtask

    task automatic test_resync();
        do_reset();
        send_sync_even(16'h1000);
        for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 8'(c), 16'h2000 + 16'(c));
        n_chk++;
        if (dout_dv !== 1'b1 || sync_out !== 1'b0 || dout_chn !== 8'd19 || dout_dp2 !== 16'h1013)
            $display("FAIL resync_pre: dv=%b so=%b chn=%0d dp2=%h, need 1 0 19 1013",
                     dout_dv, sync_out, dout_chn, dout_dp2);
        else n_pass++;
        step(1'b1, 1'b1, 8'd0, 16'h5000);
        n_chk++;
        if (dout_dv !== 1'b0 || seq_err !== 1'b0 || state_o !== 2'd1)
            $display("FAIL resync_beat: dv=%b err=%b st=%0d, need 0 0 1", dout_dv, seq_err, state_o);
        else n_pass++;
        for (int c = 1; c < 48; c++) step(1'b1, 1'b0, 8'(c), 16'h5000 + 16'(c));
        n_chk++;
        if (dout_dv !== 1'b0 || seq_err !== 1'b0)
            $display("FAIL resync_even: dv=%b err=%b, need 0 0", dout_dv, seq_err);
        else n_pass++;
        step(1'b1, 1'b0, 8'd0, 16'h6000);
        n_chk++;
        if (dout_dv !== 1'b1 || sync_out !== 1'b1 || dout_dp1 !== 16'h6000 ||
            dout_dp2 !== 16'h5000 || dout_chn !== 8'd0)
            $display("FAIL resync_out0: dv=%b so=%b dp1=%h dp2=%h chn=%0d, need 1 1 6000 5000 0",
                     dout_dv, sync_out, dout_dp1, dout_dp2, dout_chn);
        else n_pass++;
        step(1'b1, 1'b0, 8'd1, 16'h6001);
        n_chk++;
        if (dout_dv !== 1'b1 || sync_out !== 1'b0 || dout_dp2 !== 16'h5001 || dout_chn !== 8'd1)
            $display("FAIL resync_out1: dv=%b so=%b dp2=%h chn=%0d, need 1 0 5001 1",
                     dout_dv, sync_out, dout_dp2, dout_chn);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        send_sync_even(16'h1000);
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 8'(c), 16'h2000 + 16'(c));
        n_chk++;
        if (dout_dv !== 1'b1 || dout_dp1 !== 16'h2004 || dout_chn !== 8'd4)
            $display("FAIL arst_pre: dv=%b dp1=%h chn=%0d, need 1 2004 4", dout_dv, dout_dp1, dout_chn);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (dout_dv !== 1'b0 || dout_dp1 !== 16'h0 || dout_dp2 !== 16'h0 || dout_chn !== 8'h0 ||
            sync_out !== 1'b0 || seq_err !== 1'b0 || state_o !== 2'd0)
            $display("FAIL arst_now: dv=%b dp1=%h dp2=%h chn=%0d so=%b err=%b st=%0d, need all 0",
                     dout_dv, dout_dp1, dout_dp2, dout_chn, sync_out, seq_err, state_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 5; c < 48; c++) begin
            step(1'b1, 1'b0, 8'(c), 16'h2000 + 16'(c));
            n_chk++;
            if (dout_dv !== 1'b0 || state_o !== 2'd0)
                $display("FAIL arst_nosync c%0d: dv=%b st=%0d, need 0 0", c, dout_dv, state_o);
            else n_pass++;
        end
    endtask

    task automatic test_ignored_sync();
        do_reset();
        step(1'b0, 1'b1, 8'd0, 16'h1111);
        n_chk++;
        if (state_o !== 2'd0 || sync_out !== 1'b0)
            $display("FAIL ign_wait: st=%0d so=%b, need 0 0", state_o, sync_out);
        else n_pass++;
        for (int c = 0; c < 10; c++) step(1'b1, c == 0, 8'(c), 16'h1000 + 16'(c));
        step(1'b0, 1'b1, 8'd0, 16'h1111);
        n_chk++;
        if (state_o !== 2'd1 || seq_err !== 1'b0)
            $display("FAIL ign_run: st=%0d err=%b, need 1 0", state_o, seq_err);
        else n_pass++;
        for (int c = 10; c < 48; c++) step(1'b1, 1'b0, 8'(c), 16'h1000 + 16'(c));
        step(1'b1, 1'b0, 8'd0, 16'h2000);
        n_chk++;
        if (dout_dv !== 1'b1 || sync_out !== 1'b1 || dout_dp2 !== 16'h1000)
            $display("FAIL ign_out0: dv=%b so=%b dp2=%h, need 1 1 1000", dout_dv, sync_out, dout_dp2);
        else n_pass++;
        step(1'b0, 1'b1, 8'd0, 16'h1111);
        step(1'b1, 1'b0, 8'd1, 16'h2001);
        n_chk++;
        if (dout_dv !== 1'b1 || sync_out !== 1'b0 || dout_dp2 !== 16'h1001 || dout_chn !== 8'd1)
            $display("FAIL ign_out1: dv=%b so=%b dp2=%h chn=%0d, need 1 0 1001 1",
                     dout_dv, sync_out, dout_dp2, dout_chn);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; din_dv = 1'b0; sync_in = 1'b0; din_chn = '0; din_dq = '0;
        test_reset();
        test_stream(0, "nominal");
        test_stream(3, "gaps");
        test_seq_err();
        test_err_cycle_sync();
        test_resync();
        test_async_reset();
        test_ignored_sync();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prach_hb_sched.md
Name: prach_hb_sched

Overview:
Input scheduler for the PRACH half-band decimate-by-2 stage. It takes the TDM per-channel sample stream (one sample per used channel per sample period) and pairs consecutive even and odd samples of each channel into the polyphase pair (dp1, dp2) the half-band filter consumes. It emits one filter beat per channel every second sample period, together with channel index and frame sync. It also checks the channel sequence, and drops the stream until the next sync on any error.

Parameters:
NUM_CHANNEL, 128, channel slot space; depth of the even-phase store; din_chn/dout_chn index range.
NUM_CHANNEL_USED, 48, active channels per sample period, indices 0..NUM_CHANNEL_USED-1.
DATA_WIDTH, 16, sample width (signed, passed through unmodified).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
din_dq  in  DATA_WIDTH  input sample
din_dv  in  1  input beat valid
din_chn  in  8  input channel index
sync_in  in  1  frame start; qualified by din_dv; marks chn 0, even phase
dout_dp1  out  DATA_WIDTH  odd-phase sample (centre-tap path)
dout_dp2  out  DATA_WIDTH  even-phase sample (symmetric-tap path)
dout_dv  out  1  output beat valid
dout_chn  out  8  output channel index
sync_out  out  1  first output beat after accepted sync
seq_err  out  1  one-cycle pulse on sequence error
state_o  out  2  current FSM state (debug)

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: dout_dp1=0, dout_dp2=0, dout_dv=0, dout_chn=0, sync_out=0, seq_err=0, state=WAIT_SYNC, exp_chn=0, phase=EVEN, sync_pend=0. The store contents are not reset.
- Store: NUM_CHANNEL x DATA_WIDTH RAM, addressed by channel. Even-phase beats write it. Odd-phase beats read it (read-first, same cycle).
- FSM states:
  - WAIT_SYNC (0): all beats ignored. A beat with din_dv=1 and sync_in=1 is accepted as chn 0, EVEN; go to RUN.
  - RUN (1): normal operation.
  - ERR (2): transient, lasts 1 cycle; pulses seq_err=1, then WAIT_SYNC.
- sync_in with din_dv=0: ignored in every state.
- RUN, beat with din_dv=1 and sync_in=0:
  - If din_chn==exp_chn: process the beat.
  - Else: go to ERR, output nothing for this beat.
  - Channels >= NUM_CHANNEL_USED never match.
- RUN, beat with din_dv=1 and sync_in=1: resynchronise. Phase is forced to EVEN, exp_chn to 0, and the beat is processed as chn 0 EVEN, whatever the previous position. Not an error.
- Process EVEN beat: store[chn] <= din_dq. No output.
- Process ODD beat: dout_dp1 <= din_dq, dout_dp2 <= store[chn], dout_chn <= chn, dout_dv <= 1.
- Latency: exactly 1 cycle from the ODD input beat to the output beat. dout_dv=0 on all other cycles. Data and chn outputs hold their last value while dout_dv=0.
- Counter: exp_chn increments per processed beat. At NUM_CHANNEL_USED-1 it wraps to 0 and phase toggles.
- sync_out:
  - sync_pend is set by an accepted sync.
  - sync_out=1 together with the first subsequent output beat (chn 0, ODD), and sync_pend clears on it.
  - A new sync before that beat re-sets sync_pend (no double sync_out).
- Gaps: din_dv may drop for any number of cycles. The position (exp_chn, phase) is held.
- Reset mid-frame: all state returns to WAIT_SYNC immediately. The next output requires a fresh sync plus a full EVEN period.
- A beat arriving in the ERR cycle is dropped, unless it carries sync_in=1 with din_dv=1. That beat is accepted as a sync (enter RUN) and the seq_err pulse still fires.
- Throughput: one input beat per cycle sustained; output rate is half the input rate.

Decomposition:
- Package prach_pkg:
  - NUM_CHANNEL, NUM_CHANNEL_USED, DATA_WIDTH, channel index width (8).
  - State enum sched_state_e {WAIT_SYNC, RUN, ERR}.
- One sub-module: prach_chn_ram, a simple dual-port, read-first, 1-write 1-read, unregistered-read RAM of NUM_CHANNEL x DATA_WIDTH.
- FSM, counters and output register stay in the top module.

Test Plan:
- Nominal: sync on chn0, then 4 sample periods of chn 0..47. Even beats carry 0x1000+chn, odd beats 0x2000+chn. Required: 96 output beats, each dout_dp2=0x1000+chn and dout_dp1=0x2000+chn, 1 cycle after the odd input. sync_out only on the first chn0 output. seq_err never pulses.
- Gaps: same stream with din_dv low for 3 cycles after every beat. Identical output data and order; dout_dv is one cycle per odd beat.
- Sequence error: in odd period 1, send chn 5 when chn 4 is expected. Required: seq_err pulses 1 cycle and no further dout_dv until sync. After a new sync plus 48 even beats plus odd chn0, output resumes with sync_out=1.
- Mid-frame resync: sync_in with din_dv on chn 0 during odd period at chn 20. Required: no seq_err, no output for that beat. The pairing restarts; the first output is chn0 of the following odd period with sync_out=1.
- Async reset: assert rst_n=0 mid-RUN, asynchronously to clk. Required: all outputs are 0 immediately. Beats without sync produce nothing.
- Ignored sync: sync_in=1 with din_dv=0 in WAIT_SYNC and in RUN. Required: no state change and no sync_out.
